// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and FSM state type for the SPI column loader
package spi_pkg;
  localparam int NUM_COLS = 640;
  localparam int COL_ADDR_W = 10;
  localparam int COL_WORD_W = 16;
  typedef enum logic [1:0] {IDLE, HI, LO, FULL} state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: N-stage synchroniser with single-cycle rise/fall pulses
module sync_edge #(
  parameter int N = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [N-1:0] sr;
  logic prev;
  // shift the asynchronous level through N flops, keep one extra for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= {N{INIT}};
      prev <= INIT;
    end else begin
      sr <= N'({sr, d});
      prev <= sr[N-1];
    end
  assign q = sr[N-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_column_loader.sv
// spi_column_loader: pairs SPI bytes into column words in a double-buffered store
module spi_column_loader #(
  parameter int NUM_COLS = spi_pkg::NUM_COLS,
  parameter int ADDR_W = spi_pkg::COL_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [7:0] spi_byte,
  input  logic spi_byte_valid,
  input  logic spi_cs,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [spi_pkg::COL_WORD_W-1:0] rd_data,
  output logic disp_bank,
  output logic frame_done,
  output logic overrun_err
);
  import spi_pkg::*;
  localparam int DEPTH = 2 * NUM_COLS;
  state_t state, state_n;
  logic cs_q, cs_rise, cs_fall, v_q, v_rise, v_fall, unused_v;
  logic [ADDR_W-1:0] col_idx;
  logic [7:0] hi_byte;
  logic odd, byte_ev, last, hi_ld, wr_en, swap, drop, col_clr;
  logic [ADDR_W:0] wa, ra;
  logic [COL_WORD_W-1:0] mem [DEPTH];
  sync_edge #(.N(SYNC_STAGES), .INIT(1'b0)) u_valid (
    .clk(clk), .rst_n(rst_n), .d(spi_byte_valid), .q(v_q), .rise(v_rise), .fall(v_fall)
  );
  sync_edge #(.N(SYNC_STAGES), .INIT(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  assign unused_v = v_q ^ v_fall;
  assign byte_ev = v_rise & ~cs_q;
  assign last = int'(col_idx) == NUM_COLS - 1;
  assign wa = {1'b0, col_idx} + (disp_bank ? '0 : (ADDR_W+1)'(NUM_COLS));
  assign ra = {1'b0, rd_addr} + (disp_bank ? (ADDR_W+1)'(NUM_COLS) : '0);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state and per-cycle controls; cs rising beats any byte in the same cycle
  always_comb begin
    state_n = state;
    hi_ld = 1'b0;
    wr_en = 1'b0;
    swap = 1'b0;
    drop = 1'b0;
    col_clr = 1'b0;
    if (cs_rise) state_n = IDLE;
    else if (state == IDLE) begin
      state_n = cs_fall ? HI : IDLE;
      col_clr = cs_fall;
    end else if (byte_ev)
      case (state)
        HI: begin
          hi_ld = 1'b1;
          state_n = LO;
        end
        LO: begin
          wr_en = 1'b1;
          swap = last;
          state_n = last ? FULL : HI;
        end
        FULL: drop = 1'b1;
        default: ;
      endcase
  end
  // column index, high byte, bank swap and overrun tracking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_idx <= '0;
      hi_byte <= '0;
      disp_bank <= 1'b0;
      frame_done <= 1'b0;
      overrun_err <= 1'b0;
      odd <= 1'b0;
    end else begin
      frame_done <= swap;
      disp_bank <= disp_bank ^ swap;
      hi_byte <= hi_ld ? spi_byte : hi_byte;
      col_idx <= col_clr ? '0 : (wr_en && !last) ? col_idx + 1'b1 : col_idx;
      odd <= swap ? 1'b0 : odd ^ drop;
      overrun_err <= cs_fall ? 1'b0 : overrun_err | (drop & odd);
    end
  // write port into the bank not on display
  always_ff @(posedge clk)
    if (wr_en) mem[wa] <= {hi_byte, spi_byte};
  // registered read port from the displayed bank, out-of-range columns read as zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_data <= '0;
    else rd_data <= (int'(rd_addr) < NUM_COLS) ? mem[ra] : '0;
endmodule

// File: tb/tb_spi_column_loader.sv
// tb_spi_column_loader: directed frames checked against a byte-counting frame model
module tb_spi_column_loader;
  localparam int N = 640;
  logic clk = 1'b0, rst_n = 1'b0, spi_cs = 1'b1, valid = 1'b0;
  logic [7:0] spi_byte = '0;
  logic [9:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic disp_bank, frame_done, overrun_err;
  int total = 0, bad = 0, fd_cnt = 0, fd_exp = 0, m_n = 0;
  logic [15:0] mb [2][N];
  bit mk [2][N];
  bit m_disp = 0, m_ovr = 0, m_act = 0, chk_en = 0, rnd_on = 1;
  logic [7:0] m_hi = '0;

  spi_column_loader dut (
    .clk(clk), .rst_n(rst_n), .spi_byte(spi_byte), .spi_byte_valid(valid), .spi_cs(spi_cs),
    .rd_addr(rd_addr), .rd_data(rd_data), .disp_bank(disp_bank), .frame_done(frame_done),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && frame_done) fd_cnt++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // frame model: byte k of a cs-low session; odd bytes finish word k/2, word N-1 swaps banks
  task automatic m_byte(logic [7:0] b);
    int idx;
    if (!m_act) return;
    idx = m_n / 2;
    if (m_n % 2 == 0) m_hi = b;
    else if (idx < N) begin
      mb[!m_disp][idx] = {m_hi, b};
      mk[!m_disp][idx] = 1;
      if (idx == N - 1) begin
        m_disp = !m_disp;
        fd_exp++;
      end
    end else m_ovr = 1;
    m_n++;
  endtask

  task automatic send_byte(logic [7:0] b);
    chk_en = 0;
    spi_byte = b;
    valid = 1;
    tick(3);
    valid = 0;
    tick(3);
    m_byte(b);
    chk_en = 1;
    tick(2);
  endtask

  task automatic set_cs(bit v);
    chk_en = 0;
    spi_cs = v;
    tick(6);
    if (!v) begin
      m_act = 1;
      m_n = 0;
      m_ovr = 0;
    end else m_act = 0;
    chk_en = 1;
    tick(2);
  endtask

  task automatic send_words(int n, logic [15:0] base, logic [15:0] step);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      w = base + 16'(k) * step;
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
  endtask

  task automatic rd_chk(string nm, logic [9:0] a, logic [15:0] exp);
    rnd_on = 0;
    @(posedge clk);
    #1 rd_addr = a;
    @(posedge clk);
    #1 chk(nm, rd_data, exp);
    rnd_on = 1;
  endtask

  // random renderer reads while nothing directed is going on
  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_on) rd_addr = 10'($urandom_range(0, 1023));
  end

  // every settled cycle: outputs must match the frame model
  initial begin : cmp
    logic [9:0] a;
    forever begin
      @(posedge clk);
      a = rd_addr;
      #3;
      if (chk_en && rst_n) begin
        chk("disp", disp_bank, m_disp);
        chk("ovr", overrun_err, m_ovr);
        chk("fd_quiet", frame_done, 0);
        if (a >= N) chk("rd_oor", rd_data, 0);
        else if (mk[m_disp][a]) chk("rd", rd_data, mb[m_disp][a]);
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_disp", disp_bank, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_ovr", overrun_err, 0);
    chk("rst_rd", rd_data, 0);
    rst_n = 1;
    tick(6);
    chk_en = 1;
    // full frame of ascending words
    set_cs(0);
    send_words(N, 16'h0000, 16'h0001);
    set_cs(1);
    chk("t1_fd", fd_cnt, 1);
    chk("t1_disp", disp_bank, 1);
    rd_chk("t1_rd5", 5, 16'h0005);
    rd_chk("t1_rd639", 639, 16'h027F);
    rd_chk("t1_rd640", 640, 16'h0000);
    // three-byte partial frame
    set_cs(0);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h12);
    set_cs(1);
    chk("t2_fd", fd_cnt, 1);
    chk("t2_disp", disp_bank, 1);
    chk("t2_model_col0", mb[0][0], 16'hABCD);
    rd_chk("t2_rd0", 0, 16'h0000);
    // full frame plus one extra pair
    set_cs(0);
    send_words(N, 16'h1000, 16'h0001);
    chk("t3_disp", disp_bank, 0);
    send_byte(8'hEE);
    chk("t3_ovr_half", overrun_err, 0);
    send_byte(8'hFF);
    chk("t3_ovr_set", overrun_err, 1);
    rd_chk("t3_rd0", 0, 16'h1000);
    rd_chk("t3_rd639", 639, 16'h127F);
    set_cs(1);
    chk("t3_ovr_sticky", overrun_err, 1);
    set_cs(0);
    chk("t3_ovr_clr", overrun_err, 0);
    set_cs(1);
    // two constant frames
    set_cs(0);
    send_words(N, 16'hAAAA, 16'h0000);
    set_cs(1);
    chk("t4_dispA", disp_bank, 1);
    rd_chk("t4_A0", 0, 16'hAAAA);
    rd_chk("t4_A639", 639, 16'hAAAA);
    set_cs(0);
    send_words(N / 2, 16'h5555, 16'h0000);
    rd_chk("t4_midB0", 0, 16'hAAAA);
    rd_chk("t4_midB500", 500, 16'hAAAA);
    send_words(N / 2, 16'h5555, 16'h0000);
    set_cs(1);
    chk("t4_dispB", disp_bank, 0);
    chk("t4_fd", fd_cnt, 4);
    rd_chk("t4_B0", 0, 16'h5555);
    rd_chk("t4_B639", 639, 16'h5555);
    // reset in the middle of a frame at column 100
    set_cs(0);
    send_words(N, 16'h3000, 16'h0001);
    set_cs(1);
    set_cs(0);
    send_words(100, 16'h3000, 16'h0001);
    chk("t5_pre_disp", disp_bank, 1);
    @(posedge clk);
    #3;
    chk_en = 0;
    rst_n = 0;
    spi_cs = 1;
    #1;
    chk("t5_rst_disp", disp_bank, 0);
    chk("t5_rst_fd", frame_done, 0);
    chk("t5_rst_ovr", overrun_err, 0);
    chk("t5_rst_rd", rd_data, 0);
    m_disp = 0;
    m_act = 0;
    m_ovr = 0;
    tick(3);
    rst_n = 1;
    tick(6);
    chk_en = 1;
    rd_chk("t5_keep50", 50, 16'h3032);
    rd_chk("t5_keep200", 200, 16'h5555);
    set_cs(0);
    send_words(N, 16'h4000, 16'h0001);
    set_cs(1);
    chk("t5_fd", fd_cnt, 6);
    chk("t5_disp", disp_bank, 1);
    rd_chk("t5_rd7", 7, 16'h4007);
    // byte edge coincides with cs rising after a high byte
    set_cs(0);
    send_words(1, 16'h7777, 16'h0000);
    send_byte(8'h99);
    chk_en = 0;
    spi_byte = 8'h88;
    valid = 1;
    spi_cs = 1;
    tick(3);
    valid = 0;
    tick(3);
    m_act = 0;
    chk_en = 1;
    tick(2);
    chk("t6_fd", fd_cnt, 6);
    set_cs(0);
    send_words(N, 16'h6000, 16'h0001);
    set_cs(1);
    chk("t6_disp", disp_bank, 0);
    rd_chk("t6_rd0", 0, 16'h6000);
    rd_chk("t6_rd1", 1, 16'h6001);
    rd_chk("t6_rd639", 639, 16'h627F);
    chk("fd_total", fd_cnt, fd_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
